// File: rtl/mv_result_reader.sv
// Read-back unloader for the matrix-vector result vector. On the rising edge of
// done it snapshots clock_count and streams result words from data memory over valid/ready.
module mv_result_reader #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 32,
  parameter int BASE_ADDR = 2,
  parameter int MAX_ROWS  = 1022
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              done,
  input  logic [31:0]       clock_count,
  input  logic [31:0]       rows,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_last,
  output logic              busy,
  output logic              finished,
  output logic              clamp_err,
  output logic [31:0]       cycles_snap
);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_HOLD, S_FIN} state_t;

  localparam logic [ADDR_W-1:0] MAX_CNT = ADDR_W'(MAX_ROWS);
  localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);

  state_t              r_state, w_next;
  logic                r_done_q;
  logic [ADDR_W-1:0]   r_idx, r_count;
  logic                r_out_valid, r_out_last, r_clamp_err;
  logic [DATA_W-1:0]   r_out_data;
  logic [ADDR_W-1:0]   r_out_index;
  logic [31:0]         r_cycles_snap;

  logic                w_start, w_neg, w_big, w_accept;
  logic [ADDR_W-1:0]   w_cnt;

  assign w_start  = done & ~r_done_q;
  // rows is a signed count; bit 31 set means negative
  assign w_neg    = rows[31];
  assign w_big    = ~rows[31] & (rows > 32'(MAX_ROWS));
  assign w_cnt    = w_neg ? '0 : (w_big ? MAX_CNT : rows[ADDR_W-1:0]);
  assign w_accept = (r_state == S_HOLD) & r_out_valid & out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_done_q <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_done_q <= done;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_start) w_next = (w_cnt == '0) ? S_FIN : S_READ;
      S_READ: w_next = S_WAIT;
      S_WAIT: w_next = S_HOLD;
      S_HOLD: if (w_accept) w_next = r_out_last ? S_FIN : S_READ;
      S_FIN:  if (!done) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx         <= '0;
      r_count       <= '0;
      r_out_valid   <= 1'b0;
      r_out_data    <= '0;
      r_out_index   <= '0;
      r_out_last    <= 1'b0;
      r_clamp_err   <= 1'b0;
      r_cycles_snap <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_start) begin
          r_cycles_snap <= clock_count;
          r_idx         <= '0;
          r_count       <= w_cnt;
          r_clamp_err   <= w_neg | w_big;
        end
        S_WAIT: begin
          r_out_data  <= mem_rdata;
          r_out_index <= r_idx;
          r_out_last  <= (r_idx == r_count - 1'b1);
          r_out_valid <= 1'b1;
        end
        S_HOLD: if (w_accept) begin
          r_out_valid <= 1'b0;
          if (!r_out_last) r_idx <= r_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign mem_rd_en   = (r_state == S_READ);
  assign mem_addr    = (r_state == S_READ) ? BASE + r_idx : '0;
  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign out_index   = r_out_index;
  assign out_last    = r_out_last;
  assign busy        = (r_state == S_READ) | (r_state == S_WAIT) | (r_state == S_HOLD);
  assign finished    = (r_state == S_FIN);
  assign clamp_err   = r_clamp_err;
  assign cycles_snap = r_cycles_snap;

endmodule

// File: tb/tb_mv_result_reader.sv
// Directed bench for mv_result_reader: vector table of unload runs plus a
// hand-written mid-unload reset sequence.
module tb_mv_result_reader;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int BASE   = 2;

  logic              clk = 0;
  logic              reset;
  logic              done;
  logic [31:0]       clock_count;
  logic [31:0]       rows;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_index;
  logic              out_last;
  logic              busy;
  logic              finished;
  logic              clamp_err;
  logic [31:0]       cycles_snap;

  mv_result_reader dut (
    .clk(clk), .reset(reset), .done(done), .clock_count(clock_count), .rows(rows),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_last(out_last), .busy(busy), .finished(finished),
    .clamp_err(clamp_err), .cycles_snap(cycles_snap)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] mem [0:1023];
  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

  typedef struct {
    int    rows;
    int    cc;
    int    mode;   // 0: ready=1, 1: ready 0,0,1 per beat, 2: stall on index 2
    int    inj;    // re-raise done while busy
    int    exp_n;
    bit    exp_clamp;
    string name;
  } vec_t;

  vec_t vecs[8];
  int n_cmp = 0, n_err = 0;
  int mode_g = 0, hc = 0, tcount = 0, rdcnt = 0, first_rd = -1;
  bit pv = 0, pr = 0;
  logic [DATA_W-1:0] pd;
  logic [ADDR_W-1:0] pi;
  logic [DATA_W-1:0] q_data[$];
  int q_idx[$];
  bit q_last[$];
  int q_t[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // one cycle: drive at negedge, then observe what the next posedge will do
  task automatic tick();
    @(negedge clk);
    tcount++;
    clock_count = clock_count + 1;
    case (mode_g)
      0: out_ready = 1'b1;
      1: if (out_valid) begin hc++; out_ready = (hc == 3); end
         else begin hc = 0; out_ready = 1'b0; end
      default: out_ready = !(out_valid && out_index == 2);
    endcase
    if (reset) pv = 0;
    else begin
      if (mem_rd_en) begin
        rdcnt++;
        if (first_rd < 0) first_rd = tcount;
      end
      if (pv && !pr) begin
        chk("stall_valid", out_valid, 1'b1);
        chk("stall_data", {out_index, out_data}, {pi, pd});
      end
      if (out_valid && out_ready) begin
        q_data.push_back(out_data);
        q_idx.push_back(int'(out_index));
        q_last.push_back(out_last);
        q_t.push_back(tcount);
      end
      pv = out_valid; pr = out_ready; pd = out_data; pi = out_index;
    end
  endtask

  task automatic clear_obs();
    q_data.delete(); q_idx.delete(); q_last.delete(); q_t.delete();
    rdcnt = 0; first_rd = -1;
  endtask

  task automatic check_beats(input string name, input int exp_n);
    chk({name, "_nbeats"}, q_data.size(), exp_n);
    chk({name, "_nreads"}, rdcnt, exp_n);
    for (int i = 0; i < q_data.size() && i < exp_n; i++) begin
      chk({name, "_data"}, q_data[i], mem[BASE + i]);
      chk({name, "_index"}, q_idx[i], i);
      chk({name, "_last"}, q_last[i], (i == exp_n - 1));
    end
  endtask

  task automatic run_vec(input vec_t v);
    int g0, cyc;
    done = 0;
    mode_g = v.mode;
    tick(); tick();
    chk({v.name, "_rearm"}, {busy, finished}, 2'b00);
    clear_obs();
    rows = v.rows;
    clock_count = v.cc;
    done = 1;
    g0 = tcount;
    cyc = 0;
    while (!finished && cyc < 4000) begin
      tick();
      cyc++;
      if (v.inj != 0 && cyc == 5) done = 0;
      if (v.inj != 0 && cyc == 6) begin done = 1; rows = 2; clock_count = 9999; end
    end
    chk({v.name, "_finish_in_time"}, cyc < 4000, 1'b1);
    check_beats(v.name, v.exp_n);
    chk({v.name, "_snap"}, cycles_snap, v.cc);
    chk({v.name, "_clamp"}, clamp_err, v.exp_clamp);
    chk({v.name, "_busy_fin"}, busy, 1'b0);
    if (v.exp_n == 0) chk({v.name, "_fast_fin"}, cyc <= 2, 1'b1);
    if (v.mode == 0 && v.exp_n > 0) begin
      chk({v.name, "_rd_lat"}, first_rd - g0, 1);
      chk({v.name, "_beat0_lat"}, q_t[0] - g0, 3);
      for (int i = 1; i < q_t.size(); i++)
        chk({v.name, "_spacing"}, q_t[i] - q_t[i-1], 3);
    end
    // FIN holds while done stays high
    tick();
    chk({v.name, "_fin_hold"}, finished, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = i * 37 + 11;
    mem[2] = 32'd5; mem[3] = 32'hFFFF_FFFD; mem[4] = 32'd7; mem[5] = 32'd0;

    vecs[0] = '{4,    1234, 0, 0, 4,    1'b0, "basic"};
    vecs[1] = '{4,    300,  1, 0, 4,    1'b0, "stall"};
    vecs[2] = '{0,    40,   0, 0, 0,    1'b0, "zero"};
    vecs[3] = '{-1,   41,   0, 0, 0,    1'b1, "neg"};
    vecs[4] = '{1,    50,   0, 0, 1,    1'b0, "one"};
    vecs[5] = '{6,    777,  0, 1, 6,    1'b0, "inject"};
    vecs[6] = '{1100, 60,   0, 0, 1022, 1'b1, "clamp"};
    vecs[7] = '{3,    70,   1, 0, 3,    1'b0, "stall3"};

    reset = 1; done = 0; clock_count = 0; rows = 0; out_ready = 0;
    #1;
    chk("reset_outputs",
        {mem_rd_en, mem_addr, out_valid, out_data, out_index, out_last, busy, finished,
         clamp_err, cycles_snap}, '0);
    tick(); tick();
    reset = 0;
    tick();
    chk("idle_after_reset", {busy, finished, out_valid, mem_rd_en}, 4'b0000);

    foreach (vecs[i]) run_vec(vecs[i]);

    // reset during HOLD of index 2 in an 8-row run, done left high
    begin
      int cyc;
      done = 0; mode_g = 2;
      tick(); tick();
      clear_obs();
      rows = 8; clock_count = 500; done = 1;
      cyc = 0;
      while (!(out_valid && out_index == 2) && cyc < 200) begin tick(); cyc++; end
      chk("rst_reach_idx2", cyc < 200, 1'b1);
      reset = 1;
      #1;
      chk("rst_async_outputs",
          {mem_rd_en, mem_addr, out_valid, out_data, out_index, out_last, busy, finished,
           clamp_err, cycles_snap}, '0);
      mode_g = 0;
      clock_count = 600;
      tick();
      reset = 0;
      clear_obs();
      cyc = 0;
      while (!finished && cyc < 200) begin tick(); cyc++; end
      chk("rst_restart_finish", cyc < 200, 1'b1);
      check_beats("rst_restart", 8);
      chk("rst_restart_snap", cycles_snap, 32'd601);
    end

    done = 0;
    tick(); tick();
    chk("final_idle", {busy, finished}, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
